// File: rtl/program_loader_pkg.sv
// Shared loader definitions: FSM state encoding and image header layout.
// The core's load port reuses these so both sides agree on the image format.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_CAP,
        RD,
        CAP,
        PUSH,
        DONE,
        ERR
    } ld_state_e;

    // Byte offset of the length header inside the image; program bytes follow it.
    localparam logic [7:0] HDR_OFFSET = 8'd0;

endpackage

// File: rtl/program_loader_if.sv
// Byte-wide load port between the program loader and the core's program RAM.
interface program_loader_if;
    logic       valid;
    logic       ready;
    logic [7:0] addr;
    logic [7:0] data;

    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/program_loader.sv
// Program loader: reads a length-prefixed image from byte-addressed memory
// and pushes each program byte to the core with a valid/ready handshake.
// Outputs come from registers or from state decode, never from loadReady.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_AW  = 8,
    parameter int MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              memRd,
    output logic [MEM_AW-1:0] memAddr,
    input  logic [7:0]        memData,
    output logic              loadValid,
    input  logic              loadReady,
    output logic [7:0]        loadAddr,
    output logic [7:0]        loadData,
    output logic              run,
    output logic              busy,
    output logic              error
);

    // Widened limit so the length compare has headroom over the 8-bit header.
    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    ld_state_e  state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] len_q, len_d;
    logic [7:0] laddr_q, laddr_d;
    logic [7:0] ldata_q, ldata_d;
    logic       run_q;
    logic       err_q;
    logic [8:0] rd_off;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            laddr_q <= '0;
            ldata_q <= '0;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            laddr_q <= laddr_d;
            ldata_q <= ldata_d;
            run_q   <= (state_q == DONE);
            err_q   <= (state_q == ERR);
        end
    end

    // Next-state logic: header fetch, then read/capture/push per program byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        laddr_d = laddr_q;
        ldata_d = ldata_q;
        unique case (state_q)
            IDLE:    if (start) state_d = HDR_RD;
            HDR_RD:  state_d = HDR_CAP;
            HDR_CAP: begin
                len_d = memData;
                if (memData == 8'd0 || {1'b0, memData} > MAX_LEN_W) begin
                    state_d = ERR;
                end else begin
                    idx_d   = '0;
                    state_d = RD;
                end
            end
            RD:      state_d = CAP;
            CAP: begin
                ldata_d = memData;
                laddr_d = idx_q;
                state_d = PUSH;
            end
            PUSH: begin
                if (loadReady) begin
                    if (idx_q == len_q - 8'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = RD;
                    end
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobe/address and status flags decoded from the state register.
    always_comb begin
        rd_off    = {1'b0, idx_q} + {1'b0, HDR_OFFSET} + 9'd1;
        memRd     = 1'b0;
        memAddr   = '0;
        if (state_q == HDR_RD) begin
            memRd   = 1'b1;
            memAddr = MEM_AW'(HDR_OFFSET);
        end else if (state_q == RD) begin
            memRd   = 1'b1;
            memAddr = MEM_AW'(rd_off);
        end
        loadValid = (state_q == PUSH);
        busy      = (state_q == HDR_RD) || (state_q == HDR_CAP) || (state_q == RD) ||
                    (state_q == CAP)    || (state_q == PUSH);
    end

    assign loadAddr = laddr_q;
    assign loadData = ldata_q;
    assign run      = run_q;
    assign error    = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of image/handshake scenarios plus
// hand-written reset-in-PUSH sequence.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       memRd;
    logic [7:0] memAddr;
    logic [7:0] memData;
    logic       run, busy, error;

    program_loader_if lif();

    program_loader #(.MEM_AW(8), .MAX_LEN(255)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .memRd    (memRd),
        .memAddr  (memAddr),
        .memData  (memData),
        .loadValid(lif.valid),
        .loadReady(lif.ready),
        .loadAddr (lif.addr),
        .loadData (lif.data),
        .run      (run),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Image memory: registered read, data valid the cycle after memRd.
    logic [7:0] mem [0:255];
    always @(posedge clk) if (memRd) memData <= mem[memAddr];

    // Transfer scoreboard and bus observers.
    logic [15:0] xq[$];
    logic [7:0]  maxa;
    logic        post;
    int          post_act;
    always @(posedge clk) begin
        if (!reset) begin
            if (lif.valid && lif.ready) xq.push_back({lif.addr, lif.data});
            if (memRd && memAddr > maxa) maxa <= memAddr;
            if (post && (memRd || lif.valid)) post_act <= post_act + 1;
        end
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int n;          // header length byte
        int pat;        // 0: A1,B2,C3,...  1: byte k of image = k
        int stall_idx;  // transfer index held off by loadReady=0 (-1 none)
        int stall_len;  // cycles of loadReady=0
        bit spam;       // keep start high throughout the load
        int exp_cyc;    // cycles from start edge to run/error
        bit exp_err;
    } vec_t;

    function automatic logic [7:0] pat_byte(input int p, input int i);
        if (p == 0) return 8'hA1 + 8'(i) * 8'h11;
        return 8'(i + 1);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        lif.ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_image(input int n, input int p);
        for (int k = 0; k < 256; k++) mem[k] = 8'h5A;
        mem[0] = 8'(n);
        for (int i = 0; i < n; i++) mem[i + 1] = pat_byte(p, i);
        xq.delete();
        maxa = 8'h00;
        post = 1'b0;
        post_act = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit rst);
        int cyc;
        int scnt;
        bit done;
        int exp_n;
        if (rst) do_reset();
        load_image(v.n, v.pat);
        @(negedge clk);
        start = 1'b1;
        lif.ready = 1'b1;
        @(negedge clk);
        cyc = 0;
        scnt = 0;
        done = 0;
        while (!done && cyc < 2000) begin
            if (lif.valid && xq.size() == v.stall_idx && scnt < v.stall_len) begin
                lif.ready = 1'b0;
                scnt++;
                check({tag, " stall_addr"}, 32'(lif.addr), 32'(v.stall_idx));
                check({tag, " stall_data"}, 32'(lif.data), 32'(pat_byte(v.pat, v.stall_idx)));
            end else begin
                lif.ready = 1'b1;
            end
            start = v.spam;
            @(negedge clk);
            cyc++;
            if (run || error) done = 1;
        end
        start = 1'b0;
        lif.ready = 1'b1;
        check({tag, " timeout"}, 32'(done), 32'd1);
        check({tag, " cycles"}, 32'(cyc), 32'(v.exp_cyc));
        check({tag, " error"}, 32'(error), 32'(v.exp_err));
        check({tag, " run"}, 32'(run), 32'(!v.exp_err));
        exp_n = v.exp_err ? 0 : v.n;
        check({tag, " xfer_count"}, 32'(xq.size()), 32'(exp_n));
        for (int i = 0; i < xq.size() && i < exp_n; i++)
            check({tag, " xfer"}, 32'(xq[i]), 32'({8'(i), pat_byte(v.pat, i)}));
        check({tag, " max_memAddr"}, 32'(maxa), 32'(exp_n));
        // A start in DONE/ERR must not restart anything.
        post = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        post = 1'b0;
        check({tag, " post_activity"}, 32'(post_act), 32'd0);
        check({tag, " post_run"}, 32'(run), 32'(!v.exp_err));
        check({tag, " post_error"}, 32'(error), 32'(v.exp_err));
        check({tag, " post_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " memRd"}, 32'(memRd), 32'd0);
        check({tag, " memAddr"}, 32'(memAddr), 32'd0);
        check({tag, " loadValid"}, 32'(lif.valid), 32'd0);
        check({tag, " loadAddr"}, 32'(lif.addr), 32'd0);
        check({tag, " loadData"}, 32'(lif.data), 32'd0);
        check({tag, " run"}, 32'(run), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " error"}, 32'(error), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int w;
        vecs[0] = '{n: 3,   pat: 0, stall_idx: -1, stall_len: 0, spam: 0, exp_cyc: 12,  exp_err: 0};
        vecs[1] = '{n: 3,   pat: 0, stall_idx: 1,  stall_len: 4, spam: 0, exp_cyc: 16,  exp_err: 0};
        vecs[2] = '{n: 0,   pat: 0, stall_idx: -1, stall_len: 0, spam: 0, exp_cyc: 3,   exp_err: 1};
        vecs[3] = '{n: 1,   pat: 1, stall_idx: -1, stall_len: 0, spam: 0, exp_cyc: 6,   exp_err: 0};
        vecs[4] = '{n: 3,   pat: 0, stall_idx: -1, stall_len: 0, spam: 1, exp_cyc: 12,  exp_err: 0};
        vecs[5] = '{n: 255, pat: 1, stall_idx: -1, stall_len: 0, spam: 0, exp_cyc: 768, exp_err: 0};
        vecs[6] = '{n: 2,   pat: 0, stall_idx: 0,  stall_len: 1, spam: 1, exp_cyc: 10,  exp_err: 0};

        memData = 8'h00;
        do_reset();
        @(negedge clk);
        check_all_zero("reset_state");

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

        // Reset while the third byte sits in PUSH: byte dropped, all outputs cleared.
        do_reset();
        load_image(3, 0);
        @(negedge clk);
        start = 1'b1;
        lif.ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(lif.valid && xq.size() == 2) && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rst_push reached", 32'(w < 100), 32'd1);
        check("rst_push addr", 32'(lif.addr), 32'd2);
        reset = 1'b1;
        start = 1'b1;
        lif.ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check_all_zero("rst_push");
        check("rst_push dropped", 32'(xq.size()), 32'd2);
        repeat (2) @(negedge clk);
        check("rst_push idle", 32'(busy), 32'd0);
        run_vec(vecs[0], "reload", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEM_AW, default 8, image memory address width in bits.
REQ-002 Parameter MAX_LEN, default 255, largest accepted program length in bytes.
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 Ports SHALL be exactly:
  clk        in   1       rising-edge clock
  reset      in   1       synchronous active-high reset
  start      in   1       one-cycle pulse; begin load
  memRd      out  1       image memory read strobe
  memAddr    out  MEM_AW  image memory byte address
  memData    in   8       read data, valid the cycle after memRd
  loadValid  out  1       loadAddr/loadData valid toward core
  loadReady  in   1       core accepts byte this cycle
  loadAddr   out  8       core RAM address of byte
  loadData   out  8       byte to write
  run        out  1       program loaded; core may execute
  busy       out  1       load in progress
  error      out  1       header rejected

Function
REQ-005 Image format SHALL be: byte 0 = length N; bytes 1..N = program, copied to core addresses 0..N-1.
REQ-006 The FSM SHALL have states IDLE, HDR_RD, HDR_CAP, RD, CAP, PUSH, DONE, ERR.
REQ-007 IDLE: start=1 -> HDR_RD; otherwise stay; start SHALL be ignored in every other state.
REQ-008 HDR_RD: memRd=1, memAddr=0 -> HDR_CAP.
REQ-009 HDR_CAP: latch N=memData; N==0 or N>MAX_LEN -> ERR; otherwise idx=0 -> RD.
REQ-010 RD: memRd=1, memAddr=idx+1 -> CAP.
REQ-011 CAP: loadData<=memData, loadAddr<=idx -> PUSH.
REQ-012 PUSH: loadValid=1, loadAddr/loadData held stable until loadReady=1.
REQ-013 PUSH with loadReady=1: idx==N-1 -> DONE; otherwise idx+1 -> RD.
REQ-014 Transfer latency SHALL be 3 cycles per byte when loadReady is held high; total start-to-run = 2 + 3N cycles +1 registering cycle.
REQ-015 DONE: run=1, held until reset; no further memRd or loadValid.
REQ-016 ERR: error=1, held until reset; run stays 0.
REQ-017 busy SHALL be 1 in HDR_RD, HDR_CAP, RD, CAP, PUSH; 0 otherwise.
REQ-018 memRd SHALL be 0 outside HDR_RD and RD; memAddr SHALL be 0 when memRd=0.
REQ-019 idx SHALL be 8 bits; memAddr=idx+1 SHALL be zero-extended to MEM_AW and never wrap for N<=MAX_LEN.
REQ-020 All outputs SHALL be registered or decoded from state registers only; no combinational path from loadReady to any output.

Reset
REQ-021 reset=1 at any clk edge, in any state, SHALL force IDLE, idx=0, N=0, loadAddr=0, loadData=0, loadValid=0, memRd=0, memAddr=0, run=0, busy=0, error=0.
REQ-022 reset SHALL take priority over start and loadReady in the same cycle.
REQ-023 A byte in PUSH at reset SHALL be dropped, not transferred.

Structure
REQ-024 State encodings and the header offset constant (0) SHALL live in the shared loader package, reused by the core's load port.
REQ-025 The block SHALL be a single module, no sub-modules.

Verification
REQ-026 Image {03,A1,B2,C3}, start pulse, loadReady=1 -> transfers (00,A1),(01,B2),(02,C3); run=1 at cycle 12 after start; error=0.
REQ-027 Same image, loadReady low for 4 cycles during second PUSH -> loadAddr=01, loadData=B2 stable throughout; single transfer; run delayed 4 cycles.
REQ-028 Image byte0=00 -> error=1 at cycle 3, no loadValid, run=0; start pulse afterward ignored.
REQ-029 N=MAX_LEN=255, incrementing pattern -> last transfer loadAddr=FE, memAddr max=FF, run=1; no wrap.
REQ-030 reset asserted in PUSH of byte 2 -> next cycle all outputs 0, state IDLE; fresh start reloads from byte 0 correctly.
REQ-031 start pulsed during RD and in DONE -> no effect on idx, run, or transfer sequence.
